// File: rtl/cc_mux_scan_sequencer_pkg.sv
// Shared definitions for the mux scan sequencer: FSM encoding and default sizing.
package cc_mux_scan_sequencer_pkg;

  localparam int MUXSCAN_SELECTWIDTH_DEF = 2;
  localparam int MUXSCAN_DATAWIDTH_DEF   = 4;
  localparam int MUXSCAN_PERIODWIDTH_DEF = 16;
  localparam int CHANNELS                = MUXSCAN_DATAWIDTH_DEF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DWELL  = 2'b01,
    ST_SAMPLE = 2'b10
  } muxscan_state_t;

endpackage

// File: rtl/cc_mux_next_channel.sv
// Rotating priority encoder: first set mask bit strictly above i_current, wrapping.
// With i_current = all-ones it returns the lowest set bit.
module cc_mux_next_channel
  import cc_mux_scan_sequencer_pkg::*;
#(
  parameter int SELECTWIDTH = MUXSCAN_SELECTWIDTH_DEF,
  parameter int DATAWIDTH   = CHANNELS
) (
  input  logic [DATAWIDTH-1:0]   i_mask,
  input  logic [SELECTWIDTH-1:0] i_current,
  output logic [SELECTWIDTH-1:0] o_next,
  output logic                   o_wrap,
  output logic                   o_any
);

  logic [SELECTWIDTH-1:0] w_next;
  logic [SELECTWIDTH-1:0] w_cand;

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    w_next = i_current;
    w_cand = i_current;
    for (int k = DATAWIDTH; k >= 1; k--) begin
      w_cand = i_current + SELECTWIDTH'(k);
      if (i_mask[w_cand]) begin
        w_next = w_cand;
      end else begin
        w_next = w_next;
      end
    end
  end

  assign o_next = w_next;
  assign o_any  = |i_mask;
  assign o_wrap = (w_next <= i_current);

endmodule

// File: rtl/cc_mux_scan_sequencer.sv
// Steps a mux select through the enabled channels with a programmable dwell,
// sampling the mux output back on the last cycle of each channel.
module cc_mux_scan_sequencer
  import cc_mux_scan_sequencer_pkg::*;
#(
  parameter int MUXSCAN_SELECTWIDTH = MUXSCAN_SELECTWIDTH_DEF,
  parameter int MUXSCAN_DATAWIDTH   = MUXSCAN_DATAWIDTH_DEF,
  parameter int MUXSCAN_PERIODWIDTH = MUXSCAN_PERIODWIDTH_DEF
) (
  input  logic                           CC_MUXSCAN_CLOCK_50,
  input  logic                           CC_MUXSCAN_RESET_InLow,
  input  logic                           CC_MUXSCAN_enable_In,
  input  logic [MUXSCAN_DATAWIDTH-1:0]   CC_MUXSCAN_mask_InBUS,
  input  logic [MUXSCAN_PERIODWIDTH-1:0] CC_MUXSCAN_period_InBUS,
  input  logic                           CC_MUXSCAN_z_In,
  output logic [MUXSCAN_SELECTWIDTH-1:0] CC_MUXSCAN_select_OutBUS,
  output logic [MUXSCAN_DATAWIDTH-1:0]   CC_MUXSCAN_data_OutBUS,
  output logic                           CC_MUXSCAN_sample_Out,
  output logic                           CC_MUXSCAN_frame_Out,
  output logic                           CC_MUXSCAN_busy_Out
);

  localparam logic [MUXSCAN_PERIODWIDTH-1:0] P_ONE = {{(MUXSCAN_PERIODWIDTH-1){1'b0}}, 1'b1};

  muxscan_state_t                 r_state,  w_state_nx;
  logic [MUXSCAN_SELECTWIDTH-1:0] r_select, w_select_nx;
  logic [MUXSCAN_DATAWIDTH-1:0]   r_data,   w_data_nx;
  logic [MUXSCAN_PERIODWIDTH-1:0] r_count,  w_count_nx;
  logic                           r_sample, w_sample_nx;
  logic                           r_frame,  w_frame_nx;
  logic                           r_busy,   w_busy_nx;

  logic [MUXSCAN_PERIODWIDTH-1:0] w_load;
  logic [MUXSCAN_SELECTWIDTH-1:0] w_cur;
  logic [MUXSCAN_SELECTWIDTH-1:0] w_next;
  logic                           w_wrap;
  logic                           w_any;

  // A zero period behaves as a one-cycle dwell.
  assign w_load = (CC_MUXSCAN_period_InBUS == '0) ? '0 : (CC_MUXSCAN_period_InBUS - P_ONE);
  assign w_cur  = (r_state == ST_SAMPLE) ? r_select : '1;

  cc_mux_next_channel #(
    .SELECTWIDTH (MUXSCAN_SELECTWIDTH),
    .DATAWIDTH   (MUXSCAN_DATAWIDTH)
  ) u_next (
    .i_mask    (CC_MUXSCAN_mask_InBUS),
    .i_current (w_cur),
    .o_next    (w_next),
    .o_wrap    (w_wrap),
    .o_any     (w_any)
  );

  // Next-state and next-output logic for the scan FSM.
  always_comb begin
    w_state_nx  = r_state;
    w_select_nx = r_select;
    w_data_nx   = r_data;
    w_count_nx  = r_count;
    w_sample_nx = 1'b0;
    w_frame_nx  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (CC_MUXSCAN_enable_In && w_any) begin
          w_select_nx = w_next;
          w_count_nx  = w_load;
          w_state_nx  = ST_DWELL;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_DWELL: begin
        if (!CC_MUXSCAN_enable_In) begin
          w_state_nx = ST_IDLE;
        end else if (r_count == '0) begin
          w_state_nx = ST_SAMPLE;
        end else begin
          w_count_nx = r_count - P_ONE;
        end
      end
      ST_SAMPLE: begin
        w_data_nx[r_select] = CC_MUXSCAN_z_In;
        w_sample_nx         = 1'b1;
        w_frame_nx          = w_wrap & w_any;
        if (!w_any || !CC_MUXSCAN_enable_In) begin
          w_state_nx = ST_IDLE;
        end else begin
          w_select_nx = w_next;
          w_count_nx  = w_load;
          w_state_nx  = ST_DWELL;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
    w_busy_nx = (w_state_nx != ST_IDLE);
  end

  // State and output registers; reset clears any partial capture.
  always_ff @(posedge CC_MUXSCAN_CLOCK_50) begin
    if (!CC_MUXSCAN_RESET_InLow) begin
      r_state  <= ST_IDLE;
      r_select <= '0;
      r_data   <= '0;
      r_count  <= '0;
      r_sample <= 1'b0;
      r_frame  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_select <= w_select_nx;
      r_data   <= w_data_nx;
      r_count  <= w_count_nx;
      r_sample <= w_sample_nx;
      r_frame  <= w_frame_nx;
      r_busy   <= w_busy_nx;
    end
  end

  assign CC_MUXSCAN_select_OutBUS = r_select;
  assign CC_MUXSCAN_data_OutBUS   = r_data;
  assign CC_MUXSCAN_sample_Out    = r_sample;
  assign CC_MUXSCAN_frame_Out     = r_frame;
  assign CC_MUXSCAN_busy_Out      = r_busy;

endmodule

// File: tb/tb_cc_mux_scan_sequencer.sv
// Directed bench for cc_mux_scan_sequencer; z_In is driven by a 4:1 mux model of lane values.
module tb_cc_mux_scan_sequencer;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [3:0]  mask;
  logic [15:0] period;
  logic        z;
  logic [1:0]  sel;
  logic [3:0]  data;
  logic        sample;
  logic        frame;
  logic        busy;
  logic [3:0]  lanes;

  int n_cmp;
  int n_err;

  cc_mux_scan_sequencer #(
    .MUXSCAN_SELECTWIDTH (2),
    .MUXSCAN_DATAWIDTH   (4),
    .MUXSCAN_PERIODWIDTH (16)
  ) dut (
    .CC_MUXSCAN_CLOCK_50      (clk),
    .CC_MUXSCAN_RESET_InLow   (rst_n),
    .CC_MUXSCAN_enable_In     (en),
    .CC_MUXSCAN_mask_InBUS    (mask),
    .CC_MUXSCAN_period_InBUS  (period),
    .CC_MUXSCAN_z_In          (z),
    .CC_MUXSCAN_select_OutBUS (sel),
    .CC_MUXSCAN_data_OutBUS   (data),
    .CC_MUXSCAN_sample_Out    (sample),
    .CC_MUXSCAN_frame_Out     (frame),
    .CC_MUXSCAN_busy_Out      (busy)
  );

  assign z = lanes[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Dwell ticks with select held, then the capture edge.
  task automatic run_channel(input int ch, input int nxt, input int dwell,
                             input logic exp_frame, input logic [3:0] exp_data);
    for (int i = 0; i < dwell; i++) begin
      tick();
      chk("dwell_sel", 32'(sel), 32'(ch));
      chk("dwell_sample", 32'(sample), 32'd0);
      chk("dwell_frame", 32'(frame), 32'd0);
    end
    tick();
    chk("cap_sample", 32'(sample), 32'd1);
    chk("cap_frame", 32'(frame), 32'(exp_frame));
    chk("cap_sel", 32'(sel), 32'(nxt));
    chk("cap_data", 32'(data), 32'(exp_data));
    chk("cap_busy", 32'(busy), 32'd1);
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    en     = 1'b1;
    mask   = 4'b1111;
    period = 16'd3;
    lanes  = 4'b1010;

    // Reset held three cycles with enable high.
    tick(); tick(); tick();
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_sample", 32'(sample), 32'd0);
    chk("rst_frame", 32'(frame), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_sel", 32'(sel), 32'd0);

    // Full sweep, period 3: four cycles per channel.
    run_channel(0, 1, 3, 1'b0, 4'b0000);
    run_channel(1, 2, 3, 1'b0, 4'b0010);
    run_channel(2, 3, 3, 1'b0, 4'b0010);
    run_channel(3, 0, 3, 1'b1, 4'b1010);

    // Stop, then masked sweep with period 0.
    en = 1'b0;
    tick();
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_sel", 32'(sel), 32'd0);
    chk("stop_data", 32'(data), 32'h0a);
    mask   = 4'b0101;
    period = 16'd0;
    lanes  = 4'b0100;
    en     = 1'b1;
    tick();
    chk("m_start_sel", 32'(sel), 32'd0);
    chk("m_start_busy", 32'(busy), 32'd1);
    run_channel(0, 2, 1, 1'b0, 4'b1010);
    run_channel(2, 0, 1, 1'b1, 4'b1110);
    run_channel(0, 2, 1, 1'b0, 4'b1110);
    run_channel(2, 0, 1, 1'b1, 4'b1110);

    // Abort mid-dwell on channel 2; new period applies on the next load.
    period = 16'd3;
    run_channel(0, 2, 1, 1'b0, 4'b1110);
    lanes = 4'b0000;
    tick();
    chk("ab_dwell_sel", 32'(sel), 32'd2);
    en = 1'b0;
    tick();
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_sel", 32'(sel), 32'd2);
    chk("ab_sample", 32'(sample), 32'd0);
    chk("ab_data", 32'(data), 32'h0e);
    tick();
    chk("ab_idle_sample", 32'(sample), 32'd0);
    chk("ab_idle_sel", 32'(sel), 32'd2);
    en    = 1'b1;
    lanes = 4'b0001;
    tick();
    chk("re_sel", 32'(sel), 32'd0);
    chk("re_busy", 32'(busy), 32'd1);
    run_channel(0, 2, 3, 1'b0, 4'b1111);

    // Mask dropped during dwell: channel 2 still completes, then idle.
    tick();
    chk("md_sel", 32'(sel), 32'd2);
    mask = 4'b0000;
    tick();
    tick();
    chk("md_pre_sample", 32'(sample), 32'd0);
    chk("md_pre_busy", 32'(busy), 32'd1);
    tick();
    chk("md_sample", 32'(sample), 32'd1);
    chk("md_busy", 32'(busy), 32'd0);
    chk("md_sel", 32'(sel), 32'd2);
    chk("md_data", 32'(data), 32'h0b);
    tick();
    chk("md_after_sample", 32'(sample), 32'd0);
    chk("md_after_busy", 32'(busy), 32'd0);

    // Reset asserted while in SAMPLE with z high.
    mask   = 4'b1111;
    period = 16'd0;
    lanes  = 4'b1111;
    tick();
    chk("rs_load_busy", 32'(busy), 32'd1);
    tick();
    chk("rs_pre_sample", 32'(sample), 32'd0);
    rst_n = 1'b0;
    tick();
    chk("rs_data", 32'(data), 32'd0);
    chk("rs_sel", 32'(sel), 32'd0);
    chk("rs_sample", 32'(sample), 32'd0);
    chk("rs_frame", 32'(frame), 32'd0);
    chk("rs_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    en    = 1'b0;
    tick();
    chk("rs_idle_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
